// File: rtl/pushbutton_pkg.sv
// Shared types and default timing for the KEY pushbutton conditioning path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pushbutton_pkg;

  // Debounce FSM: two stable states, each with a pending state that qualifies a change.
  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    PRESSED         = 2'd2,
    RELEASE_PENDING = 2'd3
  } db_state_e;

  // 20 ms stable time at 50 MHz.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  // 500 ms before the first auto-repeat, then 100 ms between repeats.
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 25_000_000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 5_000_000;

endpackage

// File: rtl/pushbutton_debounce_if.sv
// Bundle of the raw button input and the conditioned button outputs.
// Latency: none (wiring only).
// Backpressure: none; strobes are single-cycle and must be sampled every cycle.
interface pushbutton_debounce_if;

  logic i_button;        // raw KEY, asynchronous, 0 = depressed
  logic o_pressed;       // debounced level, 1 = held
  logic o_pressPulse;    // one-cycle strobe per accepted press / auto-repeat
  logic o_releasePulse;  // one-cycle strobe per accepted release

  // Board or bench side: drives the button, observes the conditioned outputs.
  modport master (
    output i_button,
    input  o_pressed,
    input  o_pressPulse,
    input  o_releasePulse
  );

  // Debouncer side.
  modport slave (
    input  i_button,
    output o_pressed,
    output o_pressPulse,
    output o_releasePulse
  );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous level input, reusable for any KEY or SW.
// Latency: 2 cycles from the capturing edge of the first flop.
// Backpressure: none; the output follows the input continuously.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Shift the raw level through the two-stage chain.
  always_comb begin
    meta_d = i_d;
    sync_d = meta_q;
  end

  // Both stages come out of reset at the idle level so no false edge is seen.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign o_q = sync_q;

endmodule

// File: rtl/pushbutton_debounce.sv
// Debounces one active-low KEY into a level plus press/release strobes; define
// DEBOUNCE_AUTOREPEAT_EN to add auto-repeat press strobes while held.
// Latency: strobe in the cycle after edge k+DEBOUNCE_CYCLES+2 (k = first sync capture).
// Backpressure: none; strobes are one cycle wide and never coincide.
module pushbutton_debounce
  import pushbutton_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  pushbutton_debounce_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject configurations the counters cannot represent.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("pushbutton_debounce: illegal timing parameter");
  end

  logic             btn_s;  // synchronised button, 0 = depressed
  logic             rpt_fire;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             press_pulse_q, press_pulse_d;
  logic             release_pulse_q, release_pulse_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (bus.i_button),
    .o_q     (btn_s)
  );

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RPT_W   = $clog2(RPT_MAX + 1);

  logic [RPT_W-1:0] rpt_cnt_q, rpt_cnt_d, rpt_target;
  logic             rpt_first_q, rpt_first_d;

  // Repeat timer: idle outside the held region, frozen while a release is being qualified.
  always_comb begin
    rpt_target  = rpt_first_q ? RPT_W'(REPEAT_DELAY - 1) : RPT_W'(REPEAT_PERIOD - 1);
    rpt_fire    = (state_q == PRESSED) && !btn_s && (rpt_cnt_q == rpt_target);
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    if (state_q == RELEASED || state_q == PRESS_PENDING) begin
      rpt_cnt_d   = '0;
      rpt_first_d = 1'b1;
    end else if (state_q == PRESSED && !btn_s) begin
      if (rpt_fire) begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b0;
      end else if (rpt_cnt_q < rpt_target) begin
        rpt_cnt_d = rpt_cnt_q + RPT_W'(1);
      end
    end
  end

  // Repeat timer registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rpt_cnt_q   <= '0;
      rpt_first_q <= 1'b1;
    end else begin
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_first_q <= rpt_first_d;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  // Next state: a pending state must see DEBOUNCE_CYCLES consecutive samples of the new level.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (!btn_s) begin
          state_d = PRESS_PENDING;
          cnt_d   = '0;
        end
      end
      PRESS_PENDING: begin
        if (btn_s) begin
          state_d = RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d       = PRESSED;
          cnt_d         = '0;
          press_pulse_d = 1'b1;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (btn_s) begin
          state_d = RELEASE_PENDING;
          cnt_d   = '0;
        end else begin
          press_pulse_d = rpt_fire;
        end
      end
      RELEASE_PENDING: begin
        if (!btn_s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d         = RELEASED;
          cnt_d           = '0;
          release_pulse_d = 1'b1;
        end else if (cnt_q < CNT_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        cnt_d   = '0;
      end
    endcase
    pressed_d = (state_d == PRESSED) || (state_d == RELEASE_PENDING);
  end

  // FSM state and registered outputs; reset discards any qualification in progress.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q         <= RELEASED;
      cnt_q           <= '0;
      pressed_q       <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pressed_q       <= pressed_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
    end
  end

  assign bus.o_pressed      = pressed_q;
  assign bus.o_pressPulse   = press_pulse_q;
  assign bus.o_releasePulse = release_pulse_q;

endmodule

// File: tb/tb_pushbutton_debounce.sv
// Directed bench for pushbutton_debounce with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
// Latency: expectations are absolute edge numbers; edge n is the n-th rising clock edge.
// Backpressure: none; outputs are logged on every falling edge and checked at the end.
module tb_pushbutton_debounce;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   n_overlap = 0;
  int   press_q[$];
  int   release_q[$];
  bit   pressed_hist [0:399];

  pushbutton_debounce_if bus();

  pushbutton_debounce #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (10),
    .REPEAT_PERIOD   (5)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge n, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Log outputs mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc < 400) pressed_hist[cyc] = (bus.o_pressed === 1'b1);
    if (bus.o_pressPulse === 1'b1) press_q.push_back(cyc);
    if (bus.o_releasePulse === 1'b1) release_q.push_back(cyc);
    if (bus.o_pressPulse === 1'b1 && bus.o_releasePulse === 1'b1) n_overlap++;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Returns at the falling edge before rising edge n, so a drive lands on edge n.
  task automatic goto_edge(input int n);
    while (cyc < n - 1) @(negedge clk);
  endtask

  function automatic int count_in(input bit rel, input int lo, input int hi);
    int n = 0;
    if (rel) begin
      foreach (release_q[i]) if (release_q[i] >= lo && release_q[i] <= hi) n++;
    end else begin
      foreach (press_q[i]) if (press_q[i] >= lo && press_q[i] <= hi) n++;
    end
    return n;
  endfunction

  function automatic int first_in(input bit rel, input int lo, input int hi);
    if (rel) begin
      foreach (release_q[i]) if (release_q[i] >= lo && release_q[i] <= hi) return release_q[i];
    end else begin
      foreach (press_q[i]) if (press_q[i] >= lo && press_q[i] <= hi) return press_q[i];
    end
    return -1;
  endfunction

  initial begin
    int min_pressed;
`ifdef DEBOUNCE_AUTOREPEAT_EN
    int exp_rpt[6] = '{196, 206, 211, 216, 221, 226};
`else
    int exp_rpt[1] = '{196};
`endif
    rst_n        = 1'b0;
    bus.i_button = 1'b1;

    // Reset over edges 1..3, then the stimulus timeline.
    goto_edge(4);   rst_n = 1'b1;
    goto_edge(10);  bus.i_button = 1'b0;   // clean press
    goto_edge(40);  bus.i_button = 1'b1;   // clean release
    goto_edge(60);  bus.i_button = 1'b0;   // bounce: 0,0,1 then 0 steady
    goto_edge(62);  bus.i_button = 1'b1;
    goto_edge(63);  bus.i_button = 1'b0;
    goto_edge(75);  bus.i_button = 1'b1;   // 3-cycle release glitch
    goto_edge(78);  bus.i_button = 1'b0;
    goto_edge(100); bus.i_button = 1'b1;   // release
    goto_edge(120); bus.i_button = 1'b0;   // press, reset two cycles into qualification
    goto_edge(124); rst_n = 1'b0;
    goto_edge(125); rst_n = 1'b1;
    goto_edge(150); rst_n = 1'b0;          // reset while held
    goto_edge(152); rst_n = 1'b1;
    goto_edge(170); bus.i_button = 1'b1;
    goto_edge(190); bus.i_button = 1'b0;   // long hold for auto-repeat
    goto_edge(240); bus.i_button = 1'b1;
    goto_edge(262);

    // Reset state.
    check_eq("rst_pressed",   pressed_hist[2] ? 1 : 0, 0);
    check_eq("rst_press_pls", count_in(1'b0, 1, 9), 0);
    check_eq("rst_rel_pls",   count_in(1'b1, 1, 9), 0);

    // Clean press at edge 10, release at edge 40.
    check_eq("p1_count",      count_in(1'b0, 10, 25), 1);
    check_eq("p1_time",       first_in(1'b0, 10, 25), 16);
    check_eq("p1_lvl_before", pressed_hist[15] ? 1 : 0, 0);
    check_eq("p1_lvl_at",     pressed_hist[16] ? 1 : 0, 1);
    check_eq("r1_count",      count_in(1'b1, 40, 55), 1);
    check_eq("r1_time",       first_in(1'b1, 40, 55), 46);
    check_eq("r1_lvl_before", pressed_hist[45] ? 1 : 0, 1);
    check_eq("r1_lvl_at",     pressed_hist[46] ? 1 : 0, 0);

    // Bounce: one press timed from the final falling edge 63.
    check_eq("bnc_count",     count_in(1'b0, 60, 74), 1);
    check_eq("bnc_time",      first_in(1'b0, 60, 74), 69);
    check_eq("bnc_no_rel",    count_in(1'b1, 60, 74), 0);

    // Release glitch shorter than the debounce window.
    min_pressed = 1;
    for (int c = 70; c <= 99; c++) if (!pressed_hist[c]) min_pressed = 0;
    check_eq("glt_level",     min_pressed, 1);
    check_eq("glt_no_rel",    count_in(1'b1, 75, 99), 0);
`ifndef DEBOUNCE_AUTOREPEAT_EN
    check_eq("glt_no_press",  count_in(1'b0, 75, 99), 0);
`endif
    check_eq("r2_time",       first_in(1'b1, 100, 110), 106);

    // Reset mid-qualification, button held; re-qualified from capture edge 125.
    check_eq("rq_lvl_rst",    pressed_hist[124] ? 1 : 0, 0);
    check_eq("rq_pls_rst",    count_in(1'b0, 124, 124) + count_in(1'b1, 124, 124), 0);
    check_eq("rq_count",      count_in(1'b0, 120, 135), 1);
    check_eq("rq_time",       first_in(1'b0, 120, 135), 131);

    // Reset while pressed: level drops, no release strobe, fresh press from edge 152.
    check_eq("rh_lvl_before", pressed_hist[149] ? 1 : 0, 1);
    check_eq("rh_lvl_rst",    pressed_hist[150] ? 1 : 0, 0);
    check_eq("rh_no_rel",     count_in(1'b1, 140, 165), 0);
    check_eq("rh_time",       first_in(1'b0, 150, 165), 158);

    // Long hold: single strobe, or the auto-repeat train when enabled.
    check_eq("rpt_count",     count_in(1'b0, 190, 230), $size(exp_rpt));
    foreach (exp_rpt[i]) check_eq($sformatf("rpt_at_%0d", exp_rpt[i]), count_in(1'b0, exp_rpt[i], exp_rpt[i]), 1);
    check_eq("r3_time",       first_in(1'b1, 240, 255), 246);

    check_eq("no_overlap",    n_overlap, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pushbutton_debounce.md
# pushbutton_debounce

Conditions one raw DE1-SoC KEY pushbutton into clean, single-clock-domain control for the downstream seven-bit PRBS-to-seven-segment stage. It synchronises the asynchronous, bouncing, active-low KEY input to the 50 MHz system clock. It filters the input for a programmable stable time. It emits a one-cycle press strobe that the PRBS stage uses as a clock enable, replacing direct clocking of the generator from the button.

## Interface
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a level change (20 ms at 50 MHz); legal range ≥ 2
- REPEAT_DELAY, 25_000_000, cycles held before the first auto-repeat strobe (only with DEBOUNCE_AUTOREPEAT_EN); legal range ≥ 1
- REPEAT_PERIOD, 5_000_000, cycles between subsequent auto-repeat strobes (only with DEBOUNCE_AUTOREPEAT_EN); legal range ≥ 1
- i_clk  input  1  system clock, 50 MHz
- i_rst_n  input  1  synchronous reset, active-low
- i_button  input  1  raw KEY, asynchronous; 0 = depressed
- o_pressed  output  1  debounced level; 1 = held
- o_pressPulse  output  1  one-cycle strobe on each accepted press (and each auto-repeat)
- o_releasePulse  output  1  one-cycle strobe on each accepted release

## Operation
- The two-flop synchroniser samples i_button. Its output s is the only value the FSM sees. Both flops reset to 1 (released).
- FSM states: RELEASED, PRESS_PENDING, PRESSED, RELEASE_PENDING. The debounce counter clears on every state entry.
- RELEASED: if s = 0, go to PRESS_PENDING.
- PRESS_PENDING, s = 0: the counter increments. When the counter reaches DEBOUNCE_CYCLES−1 with s still 0, go to PRESSED and register o_pressPulse = 1 for one cycle.
- PRESS_PENDING, s = 1: return to RELEASED with no strobe.
- PRESSED: if s = 1, go to RELEASE_PENDING.
- RELEASE_PENDING: mirror image of PRESS_PENDING. On success go to RELEASED with o_releasePulse for one cycle; on a glitch (s = 0) return to PRESSED with no strobe.
- o_pressed = 1 in PRESSED and RELEASE_PENDING, else 0. All outputs are registered.
- Counter width is $clog2(DEBOUNCE_CYCLES). The counter saturates and never wraps.
- Reset at any time: the FSM goes to RELEASED, counters clear, all outputs go to 0, and any pending event is discarded.
- Button held through reset: it is re-qualified as a fresh press after reset deasserts, and o_pressPulse fires.
- o_pressPulse and o_releasePulse are never high in the same cycle.

## Timing
- Edge k is the first rising edge at which the synchroniser's first flop captures a new level.
- Press: o_pressPulse is high in the cycle after edge k+DEBOUNCE_CYCLES+2, provided the level stays stable.
- o_pressed rises in the same cycle as o_pressPulse.
- Release: the same latency, with o_releasePulse.
- Any input reversal lasting ≥ 1 synchronised cycle inside the window restarts qualification from the stable state.
- Pulse width is exactly one clock cycle. The minimum spacing between press and release strobes is DEBOUNCE_CYCLES+1 cycles.

## Configuration
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined: while in PRESSED, a repeat counter runs from the press strobe. An additional o_pressPulse fires after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
- The repeat counter clears on leaving PRESSED and is frozen during RELEASE_PENDING. If the release is rejected, counting resumes.
- Undefined: exactly one o_pressPulse per accepted press. The repeat counter and the REPEAT_* parameters have no effect.

## Structure
- Shared package pushbutton_pkg holds:
  - the FSM state typedef (enum logic [1:0] with the four states above);
  - the default timing constants DEFAULT_DEBOUNCE_CYCLES, DEFAULT_REPEAT_DELAY and DEFAULT_REPEAT_PERIOD.
- Sub-module sync_2ff: two-flop synchroniser with a reset-value parameter. It is reusable for the other KEY and SW inputs.

## Test plan
- Reset then clean press. DEBOUNCE_CYCLES=4; hold i_button 0 from edge 10 onward.
  - Required: o_pressPulse high only in the cycle after edge 16; o_pressed rises with it.
  - Then release at edge 40: o_releasePulse high only after edge 46; o_pressed falls.
- Bounce rejection. DEBOUNCE_CYCLES=4; pulse i_button 0 for 2 cycles, 1 for 1, then 0 steady.
  - Required: exactly one o_pressPulse, timed from the final falling edge; no o_releasePulse.
- Release glitch. While pressed, set i_button to 1 for 3 cycles (< DEBOUNCE_CYCLES=4).
  - Required: o_pressed stays 1; no strobes.
- Reset mid-qualification. Assert i_rst_n=0 two cycles into PRESS_PENDING for 1 cycle, with the button held.
  - Required: all outputs 0 during reset; one o_pressPulse DEBOUNCE_CYCLES+2 cycles after the first post-reset capture edge.
- Auto-repeat (macro defined). DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5; hold for 30 cycles after the press strobe.
  - Required: strobes at +0, +10, +15, +20, +25, +30.
  - Undefined build: only the +0 strobe.
